dport_arbiter: RTL and testbench

Shares one memory bus port between the instruction fetch port and the load/store queue data port. Picks one requester per accepted request and records the winner in an in-order tag FIFO. Routes each memory response back to the requester that issued it. Sits between the core's fetch and lsqueue ports and the single external memory interface.

---
 rtl/dport_arbiter_pkg.sv | 10 +
 rtl/dport_arbiter_fifo.sv | 52 +++++
 rtl/dport_arbiter.sv | 144 ++++++++++++++
 tb/tb_dport_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dport_arbiter_pkg.sv
// dport_arbiter_pkg: definitions shared by the data-port arbiter slice.
//   RV_XLEN          - core data/address width
//   ARB_ID_FETCH/DATA - source IDs stored in the response tag FIFO
//   FETCH_SIZE_WORD  - request size encoding used on behalf of fetch
package dport_arbiter_pkg;
    localparam int         RV_XLEN         = 32;
    localparam logic       ARB_ID_FETCH    = 1'b0;
    localparam logic       ARB_ID_DATA     = 1'b1;
    localparam logic [1:0] FETCH_SIZE_WORD = 2'b10;
endpackage

// File: rtl/dport_arbiter_fifo.sv
// dport_arbiter_fifo: small synchronous FIFO with 2**DEPTH_X entries.
//   clk_i, reset_i (async, active high), clk_en_i gates every update
//   flush_i          - empties the FIFO
//   push_i / data_i  - write side; ignored when full
//   pop_i / data_o   - read side; data_o is the head entry, pop ignored when empty
//   full_o, empty_o  - occupancy flags
module dport_arbiter_fifo #(
    parameter int WIDTH   = 1,
    parameter int DEPTH_X = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clk_en_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << DEPTH_X;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [DEPTH_X:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[DEPTH_X] != rd_ptr[DEPTH_X]) &&
                     (wr_ptr[DEPTH_X-1:0] == rd_ptr[DEPTH_X-1:0]);
    assign do_push = clk_en_i & push_i & ~full_o;
    assign do_pop  = clk_en_i & pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr[DEPTH_X-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk_en_i && flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (DEPTH_X+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_X+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[DEPTH_X-1:0]] <= data_i;
    end
endmodule

// File: rtl/dport_arbiter.sv
// dport_arbiter: shares one memory port between instruction fetch (i*) and
// the load/store data port (d*). Requests pass combinationally to m*; the
// winner of each accepted request is queued in an in-order tag FIFO so each
// response is routed back to its issuer.
//   clk_i, reset_i (async, active high), clk_en_i gates all state updates
//   idle_o           - nothing outstanding and no held grant
//   ireq*/irsp*      - fetch request/response
//   dreq*/drsp*      - data request/response
//   mreq*/mrsp*      - shared memory request/response
// Optional: define MERLIN_DPORT_ARB_RR_EN for round-robin arbitration;
// otherwise data has fixed priority over fetch.
module dport_arbiter
    import dport_arbiter_pkg::*;
#(
    parameter int         C_OUTSTANDING_X = 2,
    parameter logic [1:0] C_FETCH_SIZE    = FETCH_SIZE_WORD
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_i,
    output logic               idle_o,
    output logic               ireqready_o,
    input  logic               ireqvalid_i,
    input  logic [1:0]         ireqhpl_i,
    input  logic [RV_XLEN-1:0] ireqaddr_i,
    input  logic               irspready_i,
    output logic               irspvalid_o,
    output logic               irsprerr_o,
    output logic [RV_XLEN-1:0] irspdata_o,
    output logic               dreqready_o,
    input  logic               dreqvalid_i,
    input  logic [1:0]         dreqsize_i,
    input  logic               dreqdvalid_i,
    input  logic [1:0]         dreqhpl_i,
    input  logic [RV_XLEN-1:0] dreqaddr_i,
    input  logic [RV_XLEN-1:0] dreqdata_i,
    input  logic               drspready_i,
    output logic               drspvalid_o,
    output logic               drsprerr_o,
    output logic               drspwerr_o,
    output logic [RV_XLEN-1:0] drspdata_o,
    input  logic               mreqready_i,
    output logic               mreqvalid_o,
    output logic [1:0]         mreqsize_o,
    output logic               mreqdvalid_o,
    output logic [1:0]         mreqhpl_o,
    output logic [RV_XLEN-1:0] mreqaddr_o,
    output logic [RV_XLEN-1:0] mreqdata_o,
    output logic               mrspready_o,
    input  logic               mrspvalid_i,
    input  logic               mrsprerr_i,
    input  logic               mrspwerr_i,
    input  logic [RV_XLEN-1:0] mrspdata_i
);
    logic tag_full, tag_empty, tag_head;
    logic lock_q, lock_id_q;
    logic prio_id, win_id, win_valid, accept, rsp_ok;

`ifdef MERLIN_DPORT_ARB_RR_EN
    logic ptr_q;
    assign prio_id = ptr_q;

    // Hand priority to the requester that did not just win.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                  ptr_q <= ARB_ID_DATA;
        else if (clk_en_i && accept)  ptr_q <= ~win_id;
    end
`else
    assign prio_id = ARB_ID_DATA;
`endif

    // A stalled grant stays with its owner so the presented payload cannot
    // change under a waiting memory port.
    always_comb begin
        win_id = prio_id;
        if (lock_q)                          win_id = lock_id_q;
        else if (ireqvalid_i && !dreqvalid_i) win_id = ARB_ID_FETCH;
        else if (dreqvalid_i && !ireqvalid_i) win_id = ARB_ID_DATA;
    end

    assign win_valid   = (win_id == ARB_ID_DATA) ? dreqvalid_i : ireqvalid_i;
    assign mreqvalid_o = win_valid & ~tag_full & ~reset_i;
    assign accept      = mreqvalid_o & mreqready_i;
    assign ireqready_o = accept & (win_id == ARB_ID_FETCH);
    assign dreqready_o = accept & (win_id == ARB_ID_DATA);

    always_comb begin
        mreqsize_o   = C_FETCH_SIZE;
        mreqdvalid_o = 1'b0;
        mreqhpl_o    = ireqhpl_i;
        mreqaddr_o   = ireqaddr_i;
        mreqdata_o   = '0;
        if (win_id == ARB_ID_DATA) begin
            mreqsize_o   = dreqsize_i;
            mreqdvalid_o = dreqdvalid_i;
            mreqhpl_o    = dreqhpl_i;
            mreqaddr_o   = dreqaddr_i;
            mreqdata_o   = dreqdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_ID_DATA;
        end else if (clk_en_i) begin
            if (accept) begin
                lock_q <= 1'b0;
            end else if (mreqvalid_o && !mreqready_i) begin
                lock_q    <= 1'b1;
                lock_id_q <= win_id;
            end
        end
    end

    // A response with no outstanding tag is never routed or consumed.
    assign rsp_ok      = mrspvalid_i & ~tag_empty & ~reset_i;
    assign irspvalid_o = rsp_ok & (tag_head == ARB_ID_FETCH);
    assign drspvalid_o = rsp_ok & (tag_head == ARB_ID_DATA);
    assign mrspready_o = rsp_ok & ((tag_head == ARB_ID_DATA) ? drspready_i : irspready_i);
    assign irsprerr_o  = mrsprerr_i;
    assign irspdata_o  = mrspdata_i;
    assign drsprerr_o  = mrsprerr_i;
    assign drspwerr_o  = mrspwerr_i;
    assign drspdata_o  = mrspdata_i;

    assign idle_o = tag_empty & ~lock_q;

    dport_arbiter_fifo #(
        .WIDTH   (1),
        .DEPTH_X (C_OUTSTANDING_X)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clk_en_i (clk_en_i),
        .flush_i  (1'b0),
        .push_i   (accept),
        .data_i   (win_id),
        .pop_i    (mrspvalid_i & mrspready_o),
        .data_o   (tag_head),
        .full_o   (tag_full),
        .empty_o  (tag_empty)
    );
endmodule

// File: tb/tb_dport_arbiter.sv
module tb_dport_arbiter;
    logic        clk = 1'b0;
    logic        rst, en;
    logic        iv, irdy, dv, dst, drdy, mready, mrv, mrerr, mwerr;
    logic [1:0]  ihpl, dsize, dhpl;
    logic [31:0] iaddr, daddr, ddata, mrdata;

    logic        idle, ireqready, irspvalid, irsprerr, dreqready, drspvalid, drsprerr, drspwerr;
    logic        mreqvalid, mreqdvalid, mrspready;
    logic [1:0]  mreqsize, mreqhpl;
    logic [31:0] irspdata, drspdata, mreqaddr, mreqdata;

    always #5 clk = ~clk;

    dport_arbiter dut (
        .clk_i(clk), .reset_i(rst), .clk_en_i(en), .idle_o(idle),
        .ireqready_o(ireqready), .ireqvalid_i(iv), .ireqhpl_i(ihpl), .ireqaddr_i(iaddr),
        .irspready_i(irdy), .irspvalid_o(irspvalid), .irsprerr_o(irsprerr), .irspdata_o(irspdata),
        .dreqready_o(dreqready), .dreqvalid_i(dv), .dreqsize_i(dsize), .dreqdvalid_i(dst),
        .dreqhpl_i(dhpl), .dreqaddr_i(daddr), .dreqdata_i(ddata),
        .drspready_i(drdy), .drspvalid_o(drspvalid), .drsprerr_o(drsprerr),
        .drspwerr_o(drspwerr), .drspdata_o(drspdata),
        .mreqready_i(mready), .mreqvalid_o(mreqvalid), .mreqsize_o(mreqsize),
        .mreqdvalid_o(mreqdvalid), .mreqhpl_o(mreqhpl), .mreqaddr_o(mreqaddr), .mreqdata_o(mreqdata),
        .mrspready_o(mrspready), .mrspvalid_i(mrv), .mrsprerr_i(mrerr), .mrspwerr_i(mwerr),
        .mrspdata_i(mrdata)
    );

    // Reference model: queue of issuer IDs (0 fetch, 1 data) plus held grant.
    int q[$];
    bit lk, lk_id;
    bit iacc, dacc;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        iv = 0; dv = 0; mrv = 0; mready = 0; irdy = 0; drdy = 0;
        mrerr = 0; mwerr = 0; dst = 0; dsize = 2'b00; ihpl = 2'b11; dhpl = 2'b00;
    endtask

    // Inputs are set just after a falling edge; check, then advance one cycle.
    task automatic step();
        bit win, mv, acc, rok, pop, head;
        #1;
        if (rst) begin q.delete(); lk = 0; end
        win  = lk ? lk_id : dv;
        mv   = (win ? dv : iv) && q.size() < 4 && !rst;
        acc  = mv && mready;
        rok  = mrv && q.size() > 0 && !rst;
        head = (q.size() > 0) ? q[0][0] : 1'b0;
        pop  = rok && (head ? drdy : irdy);
        chk("mreqvalid", mreqvalid, mv);
        if (mv) begin
            chk("mreqaddr",   mreqaddr,   win ? daddr : iaddr);
            chk("mreqsize",   mreqsize,   win ? dsize : 2'b10);
            chk("mreqdvalid", mreqdvalid, win ? dst : 1'b0);
            chk("mreqhpl",    mreqhpl,    win ? dhpl : ihpl);
            chk("mreqdata",   mreqdata,   win ? ddata : 32'h0);
        end
        chk("ireqready", ireqready, acc && !win);
        chk("dreqready", dreqready, acc && win);
        chk("irspvalid", irspvalid, rok && !head);
        chk("drspvalid", drspvalid, rok && head);
        chk("mrspready", mrspready, pop);
        if (rok && !head) begin
            chk("irspdata", irspdata, mrdata);
            chk("irsprerr", irsprerr, mrerr);
        end
        if (rok && head) begin
            chk("drspdata", drspdata, mrdata);
            chk("drsprerr", drsprerr, mrerr);
            chk("drspwerr", drspwerr, mwerr);
        end
        chk("idle", idle, q.size() == 0 && !lk);
        iacc = acc && !win;
        dacc = acc && win;
        @(posedge clk);
        if (en && !rst) begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(int'(win));
            if (acc) lk = 0;
            else if (mv) begin lk = 1; lk_id = win; end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        mrv = 1; irdy = 1; drdy = 1;
        for (int k = 0; k < 6; k++) begin mrdata = $urandom; step(); end
        quiet();
    endtask

    initial begin
        rst = 1; en = 1; iaddr = 0; daddr = 0; ddata = 0; mrdata = 0;
        quiet();
        @(negedge clk);
        step();                              // reset state
        rst = 0; step();

        // fetch alone, then its response
        iv = 1; iaddr = 32'h100; mready = 1; step();
        iv = 0; mready = 0; mrv = 1; irdy = 1; mrdata = 32'hDEADBEEF; step();
        quiet(); step();

        // contention: data wins, fetch goes next
        iv = 1; dv = 1; daddr = 32'h200; ddata = 32'h55; dst = 1; dsize = 2'b01; mready = 1; step();
        dv = 0; step();
        quiet(); drain();

        // stall with both valid: data payload stays on the bus
        iv = 1; dv = 1; daddr = 32'h200; mready = 0;
        for (int k = 0; k < 3; k++) step();
        mready = 1; step();
        dv = 0; step();
        quiet(); drain();

        // fetch stalled first keeps the grant when data turns up
        iv = 1; iaddr = 32'h300; mready = 0; step();
        dv = 1; daddr = 32'h400; step(); step();
        mready = 1; step();
        iv = 0; step();
        quiet(); drain();

        // four outstanding F,D,F,D; fifth is held off until a pop
        mready = 1;
        for (int k = 0; k < 4; k++) begin
            iv = (k % 2 == 0); dv = (k % 2 == 1); iaddr = 32'h1000 + k; daddr = 32'h2000 + k; step();
        end
        iv = 1; dv = 1; step(); step();
        iv = 0; dv = 0; mrv = 1; irdy = 1; drdy = 1;
        for (int k = 0; k < 4; k++) begin mrdata = 32'hA000 + k; step(); end
        quiet(); step();

        // data write error waits for drspready
        dv = 1; dst = 1; daddr = 32'h500; mready = 1; step();
        quiet(); mrv = 1; mwerr = 1; mrdata = 32'h77; step(); step();
        drdy = 1; step();
        quiet(); step();

        // reset with two outstanding
        mready = 1; iv = 1; step(); iv = 0; dv = 1; step();
        quiet(); rst = 1; iv = 1; step();
        rst = 0; quiet(); mrv = 1; irdy = 1; drdy = 1; step();
        quiet(); step();

        // randomized traffic with clock-enable gaps
        for (int c = 0; c < 3000; c++) begin
            if (!iv || iacc) begin iv = $urandom_range(0, 1); iaddr = $urandom; ihpl = 2'($urandom); end
            if (!dv || dacc) begin
                dv = $urandom_range(0, 1); daddr = $urandom; ddata = $urandom;
                dhpl = 2'($urandom); dsize = 2'($urandom); dst = 1'($urandom);
            end
            mready = ($urandom_range(0, 9) < 6);
            mrv = 1'($urandom); mrdata = $urandom; mrerr = 1'($urandom); mwerr = 1'($urandom);
            irdy = 1'($urandom); drdy = 1'($urandom);
            en = ($urandom_range(0, 9) < 8);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
